// File: rtl/pong_engine.sv
// pong_engine: once per frame, updates paddles, ball and score, then issues a
// four-register write burst (ball row, ball col, paddle 1 row, paddle 2 row).
//
// bus state  | meaning
// BUS_WAIT   | waiting for frame_tick
// BUS_CALC   | one cycle; game update registered at its end
// BUS_WR     | four cycles, sel=1, addr 0..3
//
// game mode  | meaning
// MODE_IDLE  | after reset; ball parked at centre
// MODE_SERVE | ball frozen at centre for SERVE_FRAMES updates
// MODE_PLAY  | ball moving, bounces and scoring active
// MODE_OVER  | a player reached WIN_SCORE; ball parked
module pong_engine #(
  parameter int HEIGHT       = 480,
  parameter int WIDTH        = 640,
  parameter int FRAME        = 10,
  parameter int BALL         = 10,
  parameter int PAD_H        = 40,
  parameter int PAD_W        = 10,
  parameter int P1_COL       = 30,
  parameter int P2_COL       = 600,
  parameter int PAD_SPEED    = 4,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  output logic       sel,
  output logic [1:0] addr,
  output logic [9:0] data_out,
  output logic [3:0] score_1,
  output logic [3:0] score_2,
  output logic       game_over
);

  typedef enum logic [1:0] {BUS_WAIT, BUS_CALC, BUS_WR} bus_t;
  typedef enum logic [1:0] {MODE_IDLE, MODE_PLAY, MODE_SERVE, MODE_OVER} mode_t;

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [8:0] ROW_C   = 9'((HEIGHT - BALL) / 2);
  localparam logic [9:0] COL_C   = 10'((WIDTH - BALL) / 2);
  localparam logic [8:0] PAD_C   = 9'((HEIGHT - PAD_H) / 2);
  localparam logic [8:0] PAD_MIN = 9'(FRAME);
  localparam logic [8:0] PAD_MAX = 9'(HEIGHT - FRAME - PAD_H);
  localparam logic signed [11:0] S_STEP    = 12'(BALL_SPEED);
  localparam logic signed [11:0] S_BALL    = 12'(BALL);
  localparam logic signed [11:0] S_PADH    = 12'(PAD_H);
  localparam logic signed [11:0] S_ROW_MIN = 12'(FRAME);
  localparam logic signed [11:0] S_ROW_MAX = 12'(HEIGHT - FRAME - BALL);
  localparam logic signed [11:0] S_COL_MIN = 12'(FRAME);
  localparam logic signed [11:0] S_COL_MAX = 12'(WIDTH - FRAME - BALL);
  localparam logic signed [11:0] S_HIT1    = 12'(P1_COL + PAD_W);
  localparam logic signed [11:0] S_HIT2    = 12'(P2_COL - BALL);

  bus_t             bus_q, bus_d;
  mode_t            mode_q, mode_d, mode_n;
  logic             sel_q, sel_d;
  logic [1:0]       addr_q, addr_d;
  logic [9:0]       data_q, data_d;
  logic [8:0]       ball_row_q, ball_row_d, row_n;
  logic [9:0]       ball_col_q, ball_col_d, col_n;
  logic [8:0]       pad1_q, pad1_d, pad1_n;
  logic [8:0]       pad2_q, pad2_d, pad2_n;
  logic             dr_q, dr_d, dr_n;   // 1: moving down
  logic             dc_q, dc_d, dc_n;   // 1: moving right
  logic [3:0]       score1_q, score1_d, s1_n;
  logic [3:0]       score2_q, score2_d, s2_n;
  logic             over_q, over_d;
  logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d, cnt_n;
  logic             start_pend_q, start_pend_d;
  logic             go, hit1, hit2;
  logic signed [11:0] row_s, col_s, nr, nc;

  function automatic logic [8:0] pad_move(input logic [8:0] row, input logic up, input logic dn);
    logic [8:0] r;
    r = row;
    if (up && !dn)
      r = (row < PAD_MIN + 9'(PAD_SPEED)) ? PAD_MIN : row - 9'(PAD_SPEED);
    else if (dn && !up)
      r = (row > PAD_MAX - 9'(PAD_SPEED)) ? PAD_MAX : row + 9'(PAD_SPEED);
    return r;
  endfunction

  function automatic logic overlap(input logic signed [11:0] row, input logic [8:0] pad);
    logic signed [11:0] p;
    p = $signed({3'b000, pad});
    return (row + S_BALL > p) && (row < p + S_PADH);
  endfunction

  assign row_s = $signed({3'b000, ball_row_q});
  assign col_s = $signed({2'b00, ball_col_q});
  assign go    = start_pend_q | start;

  // Game rules: next paddle, ball, score and mode values for the coming CALC.
  always_comb begin
    pad1_n = pad_move(pad1_q, p1_up, p1_down);
    pad2_n = pad_move(pad2_q, p2_up, p2_down);
    mode_n = mode_q;
    row_n  = ball_row_q;
    col_n  = ball_col_q;
    dr_n   = dr_q;
    dc_n   = dc_q;
    s1_n   = score1_q;
    s2_n   = score2_q;
    cnt_n  = serve_cnt_q;
    nr     = '0;
    nc     = '0;
    hit1   = 1'b0;
    hit2   = 1'b0;
    case (mode_q)
      MODE_IDLE, MODE_OVER: begin
        row_n = ROW_C;
        col_n = COL_C;
        if (go) begin
          s1_n   = '0;
          s2_n   = '0;
          pad1_n = PAD_C;
          pad2_n = PAD_C;
          dr_n   = 1'b1;
          dc_n   = 1'b1;
          cnt_n  = '0;
          mode_n = MODE_SERVE;
        end
      end
      MODE_SERVE: begin
        row_n = ROW_C;
        col_n = COL_C;
        if (serve_cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
          cnt_n  = '0;
          mode_n = MODE_PLAY;
        end else begin
          cnt_n = serve_cnt_q + 1'b1;
        end
      end
      default: begin
        nr = row_s + (dr_q ? S_STEP : -S_STEP);
        if (nr <= S_ROW_MIN) begin
          nr   = S_ROW_MIN;
          dr_n = 1'b1;
        end else if (nr >= S_ROW_MAX) begin
          nr   = S_ROW_MAX;
          dr_n = 1'b0;
        end
        nc    = col_s + (dc_q ? S_STEP : -S_STEP);
        hit1  = !dc_q && (col_s >= S_HIT1) && (nc <= S_HIT1) && overlap(nr, pad1_n);
        hit2  = dc_q && (col_s <= S_HIT2) && (nc >= S_HIT2) && overlap(nr, pad2_n);
        row_n = 9'(nr);
        if (hit1) begin
          col_n = 10'(S_HIT1);
          dc_n  = 1'b1;
        end else if (hit2) begin
          col_n = 10'(S_HIT2);
          dc_n  = 1'b0;
        end else if (nc <= S_COL_MIN) begin
          s2_n   = (score2_q == 4'hF) ? 4'hF : score2_q + 4'd1;
          dc_n   = 1'b1;
          row_n  = ROW_C;
          col_n  = COL_C;
          cnt_n  = '0;
          mode_n = (s2_n == 4'(WIN_SCORE)) ? MODE_OVER : MODE_SERVE;
        end else if (nc >= S_COL_MAX) begin
          s1_n   = (score1_q == 4'hF) ? 4'hF : score1_q + 4'd1;
          dc_n   = 1'b0;
          row_n  = ROW_C;
          col_n  = COL_C;
          cnt_n  = '0;
          mode_n = (s1_n == 4'(WIN_SCORE)) ? MODE_OVER : MODE_SERVE;
        end else begin
          col_n = 10'(nc);
        end
      end
    endcase
  end

  // Bus sequencing: commit game update in CALC, then stream the four registers.
  always_comb begin
    bus_d        = bus_q;
    sel_d        = 1'b0;
    addr_d       = 2'd0;
    data_d       = '0;
    mode_d       = mode_q;
    ball_row_d   = ball_row_q;
    ball_col_d   = ball_col_q;
    pad1_d       = pad1_q;
    pad2_d       = pad2_q;
    dr_d         = dr_q;
    dc_d         = dc_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    over_d       = over_q;
    serve_cnt_d  = serve_cnt_q;
    start_pend_d = start_pend_q | start;
    case (bus_q)
      BUS_WAIT: if (frame_tick) bus_d = BUS_CALC;
      BUS_CALC: begin
        mode_d       = mode_n;
        ball_row_d   = row_n;
        ball_col_d   = col_n;
        pad1_d       = pad1_n;
        pad2_d       = pad2_n;
        dr_d         = dr_n;
        dc_d         = dc_n;
        score1_d     = s1_n;
        score2_d     = s2_n;
        serve_cnt_d  = cnt_n;
        over_d       = (mode_n == MODE_OVER);
        start_pend_d = 1'b0;
        bus_d        = BUS_WR;
        sel_d        = 1'b1;
        addr_d       = 2'd0;
        data_d       = {1'b0, row_n};
      end
      BUS_WR: begin
        if (addr_q == 2'd3) begin
          bus_d = BUS_WAIT;
        end else begin
          sel_d  = 1'b1;
          addr_d = addr_q + 2'd1;
          case (addr_d)
            2'd1:    data_d = ball_col_q;
            2'd2:    data_d = {1'b0, pad1_q};
            default: data_d = {1'b0, pad2_q};
          endcase
        end
      end
      default: bus_d = BUS_WAIT;
    endcase
  end

  // State and output registers; reset parks the game and aborts any write burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_q        <= BUS_WAIT;
      mode_q       <= MODE_IDLE;
      sel_q        <= 1'b0;
      addr_q       <= 2'd0;
      data_q       <= '0;
      ball_row_q   <= ROW_C;
      ball_col_q   <= COL_C;
      pad1_q       <= PAD_C;
      pad2_q       <= PAD_C;
      dr_q         <= 1'b1;
      dc_q         <= 1'b1;
      score1_q     <= '0;
      score2_q     <= '0;
      over_q       <= 1'b0;
      serve_cnt_q  <= '0;
      start_pend_q <= 1'b0;
    end else begin
      bus_q        <= bus_d;
      mode_q       <= mode_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      ball_row_q   <= ball_row_d;
      ball_col_q   <= ball_col_d;
      pad1_q       <= pad1_d;
      pad2_q       <= pad2_d;
      dr_q         <= dr_d;
      dc_q         <= dc_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      over_q       <= over_d;
      serve_cnt_q  <= serve_cnt_d;
      start_pend_q <= start_pend_d;
    end
  end

  assign sel       = sel_q;
  assign addr      = addr_q;
  assign data_out  = data_q;
  assign score_1   = score1_q;
  assign score_2   = score2_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: frame-level bench for pong_engine with a rule-based game model.
module tb_pong_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic       sel;
  logic [1:0] addr;
  logic [9:0] data_out;
  logic [3:0] score_1, score_2;
  logic       game_over;

  int n_checks = 0;
  int n_pass   = 0;

  localparam int M_IDLE = 0, M_PLAY = 1, M_SERVE = 2, M_OVER = 3;
  int m_mode, m_br, m_bc, m_vr, m_vc, m_p1, m_p2, m_s1, m_s2, m_cnt;
  bit m_start_pend;
  int seen[4];

  always #5 clk = ~clk;

  pong_engine dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .sel(sel), .addr(addr), .data_out(data_out),
    .score_1(score_1), .score_2(score_2), .game_over(game_over)
  );

  // ---------------- reference model ----------------
  task automatic model_reset;
    m_mode = M_IDLE; m_br = 235; m_bc = 315; m_vr = 2; m_vc = 2;
    m_p1 = 220; m_p2 = 220; m_s1 = 0; m_s2 = 0; m_cnt = 0; m_start_pend = 0;
  endtask

  function automatic int pad_step(input int r, input bit u, input bit d);
    if (u && !d) return (r - 4 < 10) ? 10 : r - 4;
    if (d && !u) return (r + 4 > 430) ? 430 : r + 4;
    return r;
  endfunction

  task automatic model_point(input int who);
    if (who == 1) begin
      m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15; m_vc = -2;
    end else begin
      m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15; m_vc = 2;
    end
    m_br = 235; m_bc = 315; m_cnt = 0;
    m_mode = (m_s1 == 9 || m_s2 == 9) ? M_OVER : M_SERVE;
  endtask

  task automatic model_frame(input bit u1, input bit d1, input bit u2, input bit d2);
    int nr, nc;
    bit go, h1, h2;
    go = m_start_pend; m_start_pend = 0;
    m_p1 = pad_step(m_p1, u1, d1);
    m_p2 = pad_step(m_p2, u2, d2);
    if (m_mode == M_IDLE || m_mode == M_OVER) begin
      if (go) begin
        m_s1 = 0; m_s2 = 0; m_p1 = 220; m_p2 = 220; m_vr = 2; m_vc = 2;
        m_cnt = 0; m_mode = M_SERVE;
      end
      m_br = 235; m_bc = 315;
    end else if (m_mode == M_SERVE) begin
      m_br = 235; m_bc = 315; m_cnt++;
      if (m_cnt == 60) begin m_mode = M_PLAY; m_cnt = 0; end
    end else begin
      nr = m_br + m_vr;
      if (nr <= 10) begin nr = 10; m_vr = 2; end
      else if (nr >= 460) begin nr = 460; m_vr = -2; end
      nc = m_bc + m_vc;
      h1 = (m_vc < 0) && (m_bc >= 40) && (nc <= 40) && (nr + 10 > m_p1) && (nr < m_p1 + 40);
      h2 = (m_vc > 0) && (m_bc <= 590) && (nc >= 590) && (nr + 10 > m_p2) && (nr < m_p2 + 40);
      m_br = nr;
      if (h1) begin m_bc = 40; m_vc = 2; end
      else if (h2) begin m_bc = 590; m_vc = -2; end
      else if (nc <= 10) model_point(2);
      else if (nc >= 620) model_point(1);
      else m_bc = nc;
    end
  endtask

  // Ball row when it next reaches the given paddle face, from the model state.
  function automatic int predict_row(input int side);
    int r, v, n;
    r = m_br; v = m_vr;
    if (side == 1) n = (m_bc > 40) ? (m_bc - 40 + 1) / 2 : 0;
    else           n = (m_bc < 590) ? (590 - m_bc + 1) / 2 : 0;
    for (int i = 0; i < n; i++) begin
      r += v;
      if (r <= 10) begin r = 10; v = 2; end
      else if (r >= 460) begin r = 460; v = -2; end
    end
    return r;
  endfunction

  function automatic int track_target(input int side);
    return predict_row(side) - 15;
  endfunction

  function automatic int avoid_target(input int side);
    return (predict_row(side) + 5 < 240) ? 430 : 10;
  endfunction

  // ---------------- frame driver with inline checks ----------------
  task automatic do_frame(input bit u1, input bit d1, input bit u2, input bit d2,
                          input bit st, input bit tick_wr, input bit st_wr);
    int exp_v[4];
    p1_up = u1; p1_down = d1; p2_up = u2; p2_down = d2;
    if (st) begin
      start = 1'b1; m_start_pend = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_frame(u1, d1, u2, d2);
    exp_v[0] = m_br; exp_v[1] = m_bc; exp_v[2] = m_p1; exp_v[3] = m_p2;
    n_checks++;
    if (sel !== 1'b0) $display("FAIL calc_sel: sel=%b expected 0", sel);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      frame_tick = 1'b0; start = 1'b0;
      n_checks++;
      if (sel !== 1'b1 || addr !== 2'(k) || data_out !== 10'(exp_v[k]))
        $display("FAIL write%0d: sel=%b addr=%0d data=%0d expected sel=1 addr=%0d data=%0d",
                 k, sel, addr, data_out, k, exp_v[k]);
      else n_pass++;
      seen[k] = int'(data_out);
      if (k == 0 && tick_wr) frame_tick = 1'b1;
      if (k == 1 && st_wr) begin start = 1'b1; m_start_pend = 1'b1; end
    end
    @(negedge clk);
    frame_tick = 1'b0; start = 1'b0;
    n_checks++;
    if (sel !== 1'b0 || data_out !== 10'd0 || score_1 !== 4'(m_s1) || score_2 !== 4'(m_s2) ||
        game_over !== (m_mode == M_OVER))
      $display("FAIL post_frame: sel=%b data=%0d s1=%0d s2=%0d over=%b expected 0 0 %0d %0d %0d",
               sel, data_out, score_1, score_2, game_over, m_s1, m_s2, (m_mode == M_OVER));
    else n_pass++;
    if (tick_wr) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        n_checks++;
        if (sel !== 1'b0) $display("FAIL dropped_tick: sel=%b expected 0", sel);
        else n_pass++;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sel !== 1'b0 || addr !== 2'd0 || data_out !== 10'd0)
      $display("FAIL reset_bus: sel=%b addr=%0d data=%0d expected 0 0 0", sel, addr, data_out);
    else n_pass++;
    n_checks++;
    if (score_1 !== 4'd0 || score_2 !== 4'd0 || game_over !== 1'b0)
      $display("FAIL reset_score: s1=%0d s2=%0d over=%b expected 0 0 0", score_1, score_2, game_over);
    else n_pass++;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    do_frame(0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (seen[0] != 235 || seen[1] != 315 || seen[2] != 220 || seen[3] != 220)
      $display("FAIL reset_frame: got %0d %0d %0d %0d expected 235 315 220 220",
               seen[0], seen[1], seen[2], seen[3]);
    else n_pass++;
  endtask

  task automatic test_paddles;
    for (int f = 0; f < 60; f++) do_frame(1, 0, 0, 1, 0, 0, 0);
    n_checks++;
    if (seen[2] != 10 || seen[3] != 430)
      $display("FAIL paddle_sat: p1=%0d p2=%0d expected 10 430", seen[2], seen[3]);
    else n_pass++;
    for (int f = 0; f < 10; f++) do_frame(0, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (seen[2] != 50) $display("FAIL paddle_down: p1=%0d expected 50", seen[2]);
    else n_pass++;
    for (int f = 0; f < 5; f++) do_frame(1, 1, 1, 1, 0, 0, 0);
    n_checks++;
    if (seen[2] != 50 || seen[3] != 430)
      $display("FAIL paddle_both: p1=%0d p2=%0d expected 50 430", seen[2], seen[3]);
    else n_pass++;
  endtask

  task automatic test_serve;
    do_frame(0, 0, 0, 0, 1, 0, 0);
    for (int f = 0; f < 60; f++) do_frame(0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (seen[0] != 235 || seen[1] != 315 || seen[2] != 220)
      $display("FAIL serve_hold: ball=%0d,%0d p1=%0d expected 235,315 220", seen[0], seen[1], seen[2]);
    else n_pass++;
    do_frame(0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (seen[0] != 237 || seen[1] != 317)
      $display("FAIL serve_release: ball=%0d,%0d expected 237,317", seen[0], seen[1]);
    else n_pass++;
  endtask

  // Player 1 returns every ball, player 2 dodges it: player 1 wins 9-0.
  task automatic test_game_over;
    int t1, t2;
    for (int f = 0; f < 6000 && m_mode != M_OVER; f++) begin
      t1 = track_target(1);
      t2 = avoid_target(2);
      do_frame(m_p1 > t1 + 3, m_p1 < t1 - 3, m_p2 > t2 + 3, m_p2 < t2 - 3, 0, 0, 0);
    end
    n_checks++;
    if (game_over !== 1'b1 || score_1 !== 4'd9 || score_2 !== 4'd0)
      $display("FAIL game_over: over=%b s1=%0d s2=%0d expected 1 9 0", game_over, score_1, score_2);
    else n_pass++;
    do_frame(1, 0, 0, 1, 0, 0, 0);
    n_checks++;
    if (seen[0] != 235 || seen[1] != 315)
      $display("FAIL over_hold: ball=%0d,%0d expected 235,315", seen[0], seen[1]);
    else n_pass++;
  endtask

  // Start pulsed mid-burst is remembered; an extra tick in the burst is ignored.
  task automatic test_restart;
    do_frame(0, 0, 0, 0, 0, 1, 1);
    n_checks++;
    if (game_over !== 1'b1) $display("FAIL restart_early: over=%b expected 1", game_over);
    else n_pass++;
    do_frame(0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (score_1 !== 4'd0 || score_2 !== 4'd0 || game_over !== 1'b0 || seen[2] != 220)
      $display("FAIL restart: s1=%0d s2=%0d over=%b p1=%0d expected 0 0 0 220",
               score_1, score_2, game_over, seen[2]);
    else n_pass++;
  endtask

  // Player 2 returns the serve, player 1 misses: first point to player 2.
  task automatic test_score2;
    int t1, t2;
    for (int f = 0; f < 1500 && m_s2 == 0; f++) begin
      t1 = avoid_target(1);
      t2 = track_target(2);
      do_frame(m_p1 > t1 + 3, m_p1 < t1 - 3, m_p2 > t2 + 3, m_p2 < t2 - 3, 0, 0, 0);
    end
    n_checks++;
    if (score_2 !== 4'd1 || score_1 !== 4'd0 || seen[0] != 235 || seen[1] != 315 || game_over !== 1'b0)
      $display("FAIL score2: s2=%0d s1=%0d ball=%0d,%0d over=%b expected 1 0 235,315 0",
               score_2, score_1, seen[0], seen[1], game_over);
    else n_pass++;
  endtask

  task automatic test_random;
    int unsigned r;
    for (int f = 0; f < 300; f++) begin
      r = $urandom;
      do_frame(r[0], r[1], r[2], r[3], r[9:5] == 5'd0, r[4], 1'b0);
    end
  endtask

  task automatic test_reset_mid_wr;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sel !== 1'b1) $display("FAIL midwr_active: sel=%b expected 1", sel);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (sel !== 1'b0 || data_out !== 10'd0)
      $display("FAIL midwr_abort: sel=%b data=%0d expected 0 0", sel, data_out);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (score_1 !== 4'd0 || score_2 !== 4'd0 || game_over !== 1'b0 || sel !== 1'b0)
      $display("FAIL midwr_state: s1=%0d s2=%0d over=%b sel=%b expected 0 0 0 0",
               score_1, score_2, game_over, sel);
    else n_pass++;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    do_frame(0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (seen[0] != 235 || seen[1] != 315 || seen[2] != 220 || seen[3] != 220)
      $display("FAIL midwr_frame: got %0d %0d %0d %0d expected 235 315 220 220",
               seen[0], seen[1], seen[2], seen[3]);
    else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_paddles();
    test_serve();
    test_game_over();
    test_restart();
    test_score2();
    test_random();
    test_reset_mid_wr();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pong_engine.md
# pong_engine

Game-logic stage feeding the `vgadisplay` object-position bus. Once per video frame it updates both paddles from player buttons, advances the ball with wall and paddle bounces, and keeps score. It then writes the four position registers (`addr` 0..3) through the `sel`/`addr`/`data` write port. Coordinates use the display convention: row is 9-bit, 0..479; column is 10-bit, 0..639; each position is the object's top-left pixel.

## Interface
Parameters:
- HEIGHT, 480, screen rows
- WIDTH, 640, screen columns
- FRAME, 10, border thickness
- BALL, 10, ball side
- PAD_H, 40, paddle height
- PAD_W, 10, paddle width
- P1_COL, 30, paddle 1 left column
- P2_COL, 600, paddle 2 left column
- PAD_SPEED, 4, paddle pixels per frame
- BALL_SPEED, 2, ball pixels per frame, per axis
- SERVE_FRAMES, 60, ball freeze after a point
- WIN_SCORE, 9, score that ends the game

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-low (reset asserted when 0)
- frame_tick  in  1  one-cycle pulse per frame, synchronous to clk
- start  in  1  one-cycle pulse; starts or restarts a game
- p1_up, p1_down, p2_up, p2_down  in  1 each  buttons, already synchronous, level-sensitive
- sel  out  1  write strobe to display
- addr  out  2  register index: 0 ball row, 1 ball column, 2 paddle 1 row, 3 paddle 2 row
- data_out  out  10  zero-extended value for `addr`
- score_1, score_2  out  4 each  scores
- game_over  out  1  high while in OVER

## Operation
- Bus FSM: WAIT, CALC, WR.
  - WAIT → CALC on `frame_tick`.
  - CALC computes all updates and registers them at its end; always → WR.
  - WR lasts 4 cycles with `sel`=1 and `addr` 0,1,2,3 in order, then → WAIT.
  - `frame_tick` outside WAIT is dropped. `start` is sampled in any bus state and acts at the next CALC.
- Game mode: IDLE, PLAY, SERVE, OVER. Reset → IDLE.
  - IDLE/OVER: ball held at centre (row 235, col 315).
  - `start` in IDLE/OVER clears scores, centres paddles (row 220), sets dr=+1, dc=+1 and enters SERVE.
  - `start` in PLAY/SERVE is ignored.
- Paddles move in every mode.
  - up only: row −= PAD_SPEED, saturating at FRAME (10).
  - down only: row += PAD_SPEED, saturating at HEIGHT−FRAME−PAD_H (430).
  - Both pressed or neither: no move.
- SERVE: ball frozen at centre. A counter counts CALCs; after SERVE_FRAMES CALCs, → PLAY.
- PLAY ball step (CALC), using ≥11-bit signed arithmetic, no wrap:
  - Rows: nr = row + dr·BALL_SPEED. If nr ≤ 10, clamp to 10 and set dr=+1. If nr ≥ 460, clamp to 460 and set dr=−1.
  - Columns: nc = col + dc·BALL_SPEED.
  - Paddle 1 hit: dc=−1, col ≥ 40, nc ≤ 40, and overlap. Result: col=40, dc=+1.
  - Paddle 2 hit: dc=+1, col ≤ 590, nc ≥ 590, and overlap. Result: col=590, dc=−1.
  - Overlap means nr+BALL > pad_row and nr < pad_row+PAD_H, using the updated paddle row.
  - No hit and nc ≤ 10: score_2 += 1, dc=+1, ball centred, → SERVE.
  - No hit and nc ≥ 620: score_1 += 1, dc=−1, ball centred, → SERVE.
  - A wall bounce and a paddle hit in the same step are both applied.
- Scores saturate at 15. When a point makes a score equal to WIN_SCORE, → OVER instead of SERVE.

## Timing
- Reset values:
  - Outputs: sel=0, addr=0, data_out=0, scores=0, game_over=0.
  - Internal state: bus FSM in WAIT, game mode IDLE, paddles at row 220, ball at centre, dr=dc=+1, serve counter=0.
- `frame_tick` high at edge T → CALC in cycle T+1 → `sel`=1 in cycles T+2..T+5 with addr 0..3. Next tick accepted from T+6.
- All outputs are registered.
- `data_out` is valid whenever `sel`=1, and is 0 when `sel`=0.
- Scores and `game_over` change at the end of CALC.
- Reset mid-WR aborts the write sequence immediately: `sel`=0.

## Test plan
- Reset → sel=0, scores=0, game_over=0. One tick → writes (0,235), (1,315), (2,220), (3,220) in cycles T+2..T+5.
- `start` then 60 ticks (SERVE), next tick → ball row 237, col 317.
- p1_up held 60 ticks → paddle 1 row 10 and stays 10. Both buttons held → row unchanged.
- Ball row 12, dr=−1, one PLAY tick → row 10, dr=+1. Next tick → row 12.
- Ball col 42, dc=−1, paddle 1 covering the ball row → col 40, dc=+1. Same with paddle 1 at row 400 → col 40, dc unchanged. A further tick reaches col 38 and continues left; ball reaching col ≤ 10 → score_2=1, ball at centre, SERVE.
- score_1=8, ball reaching col 620 → score_1=9, game_over=1. Ball held at centre. `start` → scores 0, game_over=0. Extra `frame_tick` pulses during WR produce no extra writes.
